// File: rtl/axi_line_master_if.sv
// AXI4 channel bundle between the line master and an AXI RAM slave.
// The master modport drives the request-side channels (AW, W, AR, and the B/R readies).
interface axi_line_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_line_master.sv
// Cache-side AXI4 master: one line refill or writeback per request, issued as a single
// fixed-length INCR burst, with exactly one transaction outstanding at a time.
module axi_line_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int LINE_BEATS = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic                             i_req_write,
  input  logic [ADDR_WIDTH-1:0]            i_req_addr,
  input  logic [LINE_BEATS*DATA_WIDTH-1:0] i_req_wdata,
  output logic                             o_resp_valid,
  input  logic                             i_resp_ready,
  output logic                             o_resp_write,
  output logic                             o_resp_error,
  output logic [LINE_BEATS*DATA_WIDTH-1:0] o_resp_rdata,
  axi_line_master_if.master                m_axi
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(LINE_BEATS * BYTES);
  localparam int IDX_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) + 1 : 1;
  localparam logic [CNT_W-1:0]      LAST     = CNT_W'(LINE_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);
  localparam logic [ID_WIDTH-1:0]   ID_VAL   = ID_WIDTH'(AXI_ID);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP} state_t;

  state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic                    r_err, w_err_next;
  logic                    r_write, w_write_next;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_next;
  logic [DATA_WIDTH-1:0]   r_line [LINE_BEATS];
  logic [DATA_WIDTH-1:0]   w_line_next [LINE_BEATS];
  logic                    r_arvalid, w_arvalid_next;
  logic                    r_rready, w_rready_next;
  logic                    r_awvalid, w_awvalid_next;
  logic                    r_wvalid, w_wvalid_next;
  logic                    r_wlast, w_wlast_next;
  logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_next;
  logic                    r_bready, w_bready_next;
  logic                    r_resp_valid, w_resp_valid_next;
  logic                    w_accept;

  assign o_req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept    = i_req_valid && o_req_ready;

  // Burst attributes never change: full-width INCR bursts of one line.
  assign m_axi.awid    = ID_VAL;
  assign m_axi.awlen   = 8'(LINE_BEATS - 1);
  assign m_axi.awsize  = 3'($clog2(BYTES));
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.arid    = ID_VAL;
  assign m_axi.arlen   = 8'(LINE_BEATS - 1);
  assign m_axi.arsize  = 3'($clog2(BYTES));
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.wstrb   = '1;

  assign m_axi.awaddr  = r_addr;
  assign m_axi.araddr  = r_addr;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wlast   = r_wlast;
  assign m_axi.bready  = r_bready;
  assign m_axi.rready  = r_rready;

  assign o_resp_valid = r_resp_valid;
  assign o_resp_write = r_write;
  assign o_resp_error = r_err;

  generate
    for (genvar gi = 0; gi < LINE_BEATS; gi++) begin : g_pack
      assign o_resp_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = r_line[gi];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    w_write_next = r_write;
    w_addr_next  = r_addr;
    for (int k = 0; k < LINE_BEATS; k++) begin
      w_line_next[k] = r_line[k];
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_addr_next  = i_req_addr & ~LOW_MASK;
          w_write_next = i_req_write;
          w_cnt_next   = '0;
          w_err_next   = 1'b0;
          if (i_req_write) begin
            for (int k = 0; k < LINE_BEATS; k++) begin
              w_line_next[k] = i_req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          w_state_next = i_req_write ? S_AW : S_AR;
        end
      end
      S_AR: begin
        if (m_axi.arready) w_state_next = S_R;
      end
      S_R: begin
        if (m_axi.rvalid) begin
          w_line_next[r_cnt[IDX_W-1:0]] = m_axi.rdata;
          // Beat count alone ends the burst; a misplaced rlast only flags the error.
          if ((m_axi.rresp != 2'b00) || (m_axi.rid != ID_VAL) ||
              (m_axi.rlast != (r_cnt == LAST))) begin
            w_err_next = 1'b1;
          end
          if (r_cnt == LAST) w_state_next = S_RESP;
          else               w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      S_AW: begin
        if (m_axi.awready) w_state_next = S_W;
      end
      S_W: begin
        if (m_axi.wready) begin
          if (r_cnt == LAST) w_state_next = S_B;
          else               w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      S_B: begin
        if (m_axi.bvalid) begin
          if ((m_axi.bresp != 2'b00) || (m_axi.bid != ID_VAL)) w_err_next = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (i_resp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    // Outputs are registered from the next state so they change only on handshakes.
    w_arvalid_next    = (w_state_next == S_AR);
    w_rready_next     = (w_state_next == S_R);
    w_awvalid_next    = (w_state_next == S_AW);
    w_wvalid_next     = (w_state_next == S_W);
    w_wlast_next      = (w_state_next == S_W) && (w_cnt_next == LAST);
    w_bready_next     = (w_state_next == S_B);
    w_resp_valid_next = (w_state_next == S_RESP);
    w_wdata_next      = r_wdata;
    if (w_state_next == S_W) w_wdata_next = w_line_next[w_cnt_next[IDX_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_wlast      <= 1'b0;
      r_wdata      <= '0;
      r_bready     <= 1'b0;
      r_resp_valid <= 1'b0;
      for (int k = 0; k < LINE_BEATS; k++) begin
        r_line[k] <= '0;
      end
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_err        <= w_err_next;
      r_write      <= w_write_next;
      r_addr       <= w_addr_next;
      r_arvalid    <= w_arvalid_next;
      r_rready     <= w_rready_next;
      r_awvalid    <= w_awvalid_next;
      r_wvalid     <= w_wvalid_next;
      r_wlast      <= w_wlast_next;
      r_wdata      <= w_wdata_next;
      r_bready     <= w_bready_next;
      r_resp_valid <= w_resp_valid_next;
      for (int k = 0; k < LINE_BEATS; k++) begin
        r_line[k] <= w_line_next[k];
      end
    end
  end

endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master: the bench plays the AXI slave inline and checks
// every burst field, beat and completion against hand-computed values.
module tb_axi_line_master;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [15:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic         resp_write;
  logic         resp_error;
  logic [127:0] resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  axi_line_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) axi ();

  axi_line_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .LINE_BEATS(4), .AXI_ID(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_write (resp_write),
    .o_resp_error (resp_error),
    .o_resp_rdata (resp_rdata),
    .m_axi        (axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic wr, input logic [15:0] addr, input logic [127:0] line);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = line;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = '0;
  endtask

  task automatic wait_ar(input logic [15:0] exp_addr);
    int n = 0;
    while (!axi.arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arvalid", axi.arvalid, 1'b1);
    chk("araddr", axi.araddr, exp_addr);
    chk("arlen", axi.arlen, 8'd3);
    chk("arsize", axi.arsize, 3'd2);
    chk("arburst", axi.arburst, 2'd1);
    chk("arcache", axi.arcache, 4'b0011);
    @(negedge clk);
    chk("arvalid_drop", axi.arvalid, 1'b0);
  endtask

  // Drive n beats of value base+k; err_beat gets SLVERR, rlast sits on last_beat.
  task automatic send_beats(input int n, input logic [31:0] base, input int err_beat,
                            input int last_beat);
    for (int k = 0; k < n; k++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = base + 32'(k);
      axi.rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      axi.rlast  = (k == last_beat);
      axi.rid    = 8'h00;
      chk("rready", axi.rready, 1'b1);
      @(negedge clk);
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'b00;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [127:0] line,
                          input logic [1:0] br);
    int n = 0;
    int beat = 0;
    start_req(1'b1, addr, line);
    while (!axi.awvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("awvalid", axi.awvalid, 1'b1);
    chk("awaddr", axi.awaddr, addr & 16'hFFF0);
    chk("awlen", axi.awlen, 8'd3);
    chk("awsize", axi.awsize, 3'd2);
    chk("awburst", axi.awburst, 2'd1);
    chk("wvalid_before_aw", axi.wvalid, 1'b0);
    @(negedge clk);
    chk("awvalid_drop", axi.awvalid, 1'b0);
    for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
      axi.wready = (cyc % 2 == 1);
      if (axi.wvalid && axi.wready) begin
        chk($sformatf("wdata%0d", beat), axi.wdata, line[beat*32 +: 32]);
        chk($sformatf("wlast%0d", beat), axi.wlast, (beat == 3));
        chk("wstrb", axi.wstrb, 4'hF);
        beat++;
      end
      @(negedge clk);
    end
    axi.wready = 1'b0;
    chk("w_beats", 128'(beat), 128'd4);
    chk("wvalid_after", axi.wvalid, 1'b0);
    chk("bready", axi.bready, 1'b1);
    axi.bvalid = 1'b1;
    axi.bresp  = br;
    axi.bid    = 8'h00;
    @(negedge clk);
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    chk("bready_drop", axi.bready, 1'b0);
  endtask

  task automatic finish_resp(input logic exp_w, input logic exp_e, input logic chk_data,
                             input logic [127:0] exp_line, input int stall);
    chk("resp_valid", resp_valid, 1'b1);
    chk("resp_write", resp_write, exp_w);
    chk("resp_error", resp_error, exp_e);
    if (chk_data) chk("resp_rdata", resp_rdata, exp_line);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", resp_valid, 1'b1);
      chk("stall_write", resp_write, exp_w);
      chk("stall_error", resp_error, exp_e);
      chk("stall_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_drop", resp_valid, 1'b0);
    chk("req_ready_after", req_ready, 1'b1);
  endtask

  initial begin
    axi.arready = 1'b1;
    axi.awready = 1'b1;
    axi.wready  = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    axi.rid     = '0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.bid     = '0;

    repeat (3) @(negedge clk);
    $display("reset state");
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_arvalid", axi.arvalid, 1'b0);
    chk("rst_awvalid", axi.awvalid, 1'b0);
    chk("rst_wvalid", axi.wvalid, 1'b0);
    chk("rst_wlast", axi.wlast, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_error", resp_error, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 128'd0);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", req_ready, 1'b1);
    @(negedge clk);

    $display("refill 0x0140 clean");
    start_req(1'b0, 16'h0140, '0);
    wait_ar(16'h0140);
    send_beats(4, 32'hA0, -1, 3);
    finish_resp(1'b0, 1'b0, 1'b1, 128'h000000A3_000000A2_000000A1_000000A0, 0);

    $display("refill 0x0180 slverr on beat 2");
    start_req(1'b0, 16'h0180, '0);
    wait_ar(16'h0180);
    send_beats(4, 32'hB0, 2, 3);
    finish_resp(1'b0, 1'b1, 1'b1, 128'h000000B3_000000B2_000000B1_000000B0, 0);

    $display("writeback 0x0200 with resp stall");
    do_write(16'h0200, 128'h44444444_33333333_22222222_11111111, 2'b00);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0147;
    finish_resp(1'b1, 1'b0, 1'b0, '0, 5);
    @(negedge clk);
    req_valid = 1'b0;

    $display("refill 0x0147 unaligned, accepted back-to-back");
    wait_ar(16'h0140);
    send_beats(4, 32'hC0, -1, 3);
    finish_resp(1'b0, 1'b0, 1'b1, 128'h000000C3_000000C2_000000C1_000000C0, 0);

    $display("refill 0x01C0 early rlast");
    start_req(1'b0, 16'h01C0, '0);
    wait_ar(16'h01C0);
    send_beats(4, 32'hE0, -1, 1);
    finish_resp(1'b0, 1'b1, 1'b1, 128'h000000E3_000000E2_000000E1_000000E0, 0);

    $display("writeback 0x0240 bresp slverr");
    do_write(16'h0240, 128'h88888888_77777777_66666666_55555555, 2'b10);
    finish_resp(1'b1, 1'b1, 1'b0, '0, 0);

    $display("reset during R after 2 beats");
    start_req(1'b0, 16'h0300, '0);
    wait_ar(16'h0300);
    send_beats(2, 32'hF0, -1, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rready", axi.rready, 1'b0);
    chk("mid_rst_resp_valid", resp_valid, 1'b0);
    chk("mid_rst_arvalid", axi.arvalid, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1'b1);
    @(negedge clk);

    $display("refill 0x0380 after reset");
    start_req(1'b0, 16'h0380, '0);
    wait_ar(16'h0380);
    send_beats(4, 32'hD0, -1, 3);
    finish_resp(1'b0, 1'b0, 1'b1, 128'h000000D3_000000D2_000000D1_000000D0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
